// File: rtl/sonuc_yazici_pkg.sv
// Shared execute-stage types for the write-back collector.
package sonuc_yazici_pkg;

  localparam int unsigned SONUC_RD_W   = 5;
  localparam int unsigned SONUC_VERI_W = 32;

  typedef struct packed {
    logic [SONUC_RD_W-1:0]   rd;
    logic [SONUC_VERI_W-1:0] veri;
  } sonuc_t;

  typedef enum logic {
    KAYNAK_A = 1'b0,
    KAYNAK_B = 1'b1
  } kaynak_e;

  function automatic kaynak_e diger_kaynak(input kaynak_e k);
    return (k == KAYNAK_A) ? KAYNAK_B : KAYNAK_A;
  endfunction

endpackage

// File: rtl/sonuc_yazici_fifo.sv
// Small result FIFO with registered count; count is one bit wider than the pointers.
module sonuc_fifo
  import sonuc_yazici_pkg::*;
#(
  parameter int unsigned DERINLIK = 2,
  parameter type         T        = sonuc_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic temizle_i,
  input  logic push_i,
  input  T     veri_i,
  input  logic pop_i,
  output T     veri_o,
  output logic dolu_o,
  output logic bos_o
);

  localparam int unsigned PTR_W = $clog2(DERINLIK);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem_q [DERINLIK];
  logic [PTR_W-1:0] yaz_ptr_q, yaz_ptr_d;
  logic [PTR_W-1:0] oku_ptr_q, oku_ptr_d;
  logic [CNT_W-1:0] sayac_q, sayac_d;
  logic             push_ok, pop_ok;

  assign dolu_o  = (sayac_q == CNT_W'(DERINLIK));
  assign bos_o   = (sayac_q == '0);
  assign pop_ok  = pop_i && !bos_o && !temizle_i;
  assign push_ok = push_i && (!dolu_o || pop_ok) && !temizle_i;
  assign veri_o  = mem_q[oku_ptr_q];

  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayac_d   = sayac_q;
    if (temizle_i) begin
      yaz_ptr_d = '0;
      oku_ptr_d = '0;
      sayac_d   = '0;
    end else begin
      if (push_ok) yaz_ptr_d = yaz_ptr_q + PTR_W'(1);
      if (pop_ok)  oku_ptr_d = oku_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      sayac_d = sayac_q + CNT_W'(1);
      else if (pop_ok && !push_ok) sayac_d = sayac_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayac_q   <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayac_q   <= sayac_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[yaz_ptr_q] <= veri_i;
  end

endmodule

// File: rtl/sonuc_yazici.sv
// Write-back collector: two source FIFOs round-robin arbitrated onto one registered write port.
module sonuc_yazici
  import sonuc_yazici_pkg::*;
#(
  parameter int unsigned DERINLIK = 2,
  parameter int unsigned VERI_W   = 32,
  parameter int unsigned RD_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              temizle_i,
  input  logic              a_gecerli_i,
  output logic              a_hazir_o,
  input  logic [RD_W-1:0]   a_rd_i,
  input  logic [VERI_W-1:0] a_veri_i,
  input  logic              b_gecerli_i,
  output logic              b_hazir_o,
  input  logic [RD_W-1:0]   b_rd_i,
  input  logic [VERI_W-1:0] b_veri_i,
  output logic              yaz_gecerli_o,
  input  logic              yaz_hazir_i,
  output logic [RD_W-1:0]   yaz_rd_o,
  output logic [VERI_W-1:0] yaz_veri_o,
  output logic              yaz_kaynak_o
);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [VERI_W-1:0] veri;
  } sonuc_yerel_t;

  sonuc_yerel_t a_giris, b_giris, a_cikis, b_cikis, a_bas, b_bas, secilen;
  logic         a_dolu, a_bos, b_dolu, b_bos;
  logic         a_gir, b_gir, a_aday, b_aday;
  logic         a_sec, b_sec, a_push, b_push, a_pop, b_pop;
  logic         yukle;
  kaynak_e      secim;

  logic              yaz_gecerli_q, yaz_gecerli_d;
  logic [RD_W-1:0]   yaz_rd_q, yaz_rd_d;
  logic [VERI_W-1:0] yaz_veri_q, yaz_veri_d;
  kaynak_e           yaz_kaynak_q, yaz_kaynak_d;
  kaynak_e           rr_q, rr_d;

  assign a_hazir_o = !a_dolu && !temizle_i;
  assign b_hazir_o = !b_dolu && !temizle_i;

  assign a_giris.rd   = a_rd_i;
  assign a_giris.veri = a_veri_i;
  assign b_giris.rd   = b_rd_i;
  assign b_giris.veri = b_veri_i;

  // x0 results complete the handshake but are never buffered.
  assign a_gir = a_gecerli_i && a_hazir_o && (a_rd_i != '0);
  assign b_gir = b_gecerli_i && b_hazir_o && (b_rd_i != '0);

  // An empty FIFO exposes the incoming result as its head, giving 1-cycle latency.
  assign a_aday = !a_bos || a_gir;
  assign b_aday = !b_bos || b_gir;
  assign a_bas  = a_bos ? a_giris : a_cikis;
  assign b_bas  = b_bos ? b_giris : b_cikis;

  assign yukle = !temizle_i && (!yaz_gecerli_q || yaz_hazir_i);

  always_comb begin
    secim = KAYNAK_A;
    if (a_aday && b_aday) secim = rr_q;
    else if (b_aday)      secim = KAYNAK_B;
  end

  assign a_sec   = yukle && a_aday && (secim == KAYNAK_A);
  assign b_sec   = yukle && b_aday && (secim == KAYNAK_B);
  assign a_pop   = a_sec && !a_bos;
  assign b_pop   = b_sec && !b_bos;
  assign a_push  = a_gir && !(a_sec && a_bos);
  assign b_push  = b_gir && !(b_sec && b_bos);
  assign secilen = (secim == KAYNAK_A) ? a_bas : b_bas;

  always_comb begin
    yaz_gecerli_d = yaz_gecerli_q;
    yaz_rd_d      = yaz_rd_q;
    yaz_veri_d    = yaz_veri_q;
    yaz_kaynak_d  = yaz_kaynak_q;
    rr_d          = rr_q;
    if (temizle_i) begin
      yaz_gecerli_d = 1'b0;
      yaz_rd_d      = '0;
      yaz_veri_d    = '0;
      yaz_kaynak_d  = KAYNAK_A;
    end else if (yukle) begin
      yaz_gecerli_d = a_aday || b_aday;
      if (a_aday || b_aday) begin
        yaz_rd_d     = secilen.rd;
        yaz_veri_d   = secilen.veri;
        yaz_kaynak_d = secim;
      end
      if (a_aday && b_aday) rr_d = diger_kaynak(rr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yaz_gecerli_q <= 1'b0;
      yaz_rd_q      <= '0;
      yaz_veri_q    <= '0;
      yaz_kaynak_q  <= KAYNAK_A;
      rr_q          <= KAYNAK_A;
    end else begin
      yaz_gecerli_q <= yaz_gecerli_d;
      yaz_rd_q      <= yaz_rd_d;
      yaz_veri_q    <= yaz_veri_d;
      yaz_kaynak_q  <= yaz_kaynak_d;
      rr_q          <= rr_d;
    end
  end

  assign yaz_gecerli_o = yaz_gecerli_q;
  assign yaz_rd_o      = yaz_rd_q;
  assign yaz_veri_o    = yaz_veri_q;
  assign yaz_kaynak_o  = (yaz_kaynak_q == KAYNAK_B);

  sonuc_fifo #(.DERINLIK(DERINLIK), .T(sonuc_yerel_t)) u_fifo_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .temizle_i(temizle_i),
    .push_i   (a_push),
    .veri_i   (a_giris),
    .pop_i    (a_pop),
    .veri_o   (a_cikis),
    .dolu_o   (a_dolu),
    .bos_o    (a_bos)
  );

  sonuc_fifo #(.DERINLIK(DERINLIK), .T(sonuc_yerel_t)) u_fifo_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .temizle_i(temizle_i),
    .push_i   (b_push),
    .veri_i   (b_giris),
    .pop_i    (b_pop),
    .veri_o   (b_cikis),
    .dolu_o   (b_dolu),
    .bos_o    (b_bos)
  );

endmodule

// File: tb/tb_sonuc_yazici.sv
// Scoreboard bench for sonuc_yazici: per-source expected queues, directed timing checks, random traffic.
module tb_sonuc_yazici;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] veri;
  } beklenen_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        temizle;
  logic        a_gecerli, b_gecerli, a_hazir, b_hazir;
  logic [4:0]  a_rd, b_rd, yaz_rd;
  logic [31:0] a_veri, b_veri, yaz_veri;
  logic        yaz_gecerli, yaz_hazir, yaz_kaynak;

  int checks = 0;
  int failures = 0;
  beklenen_t qa[$];
  beklenen_t qb[$];

  always #5 clk = ~clk;

  sonuc_yazici #(.DERINLIK(2), .VERI_W(32), .RD_W(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .temizle_i    (temizle),
    .a_gecerli_i  (a_gecerli),
    .a_hazir_o    (a_hazir),
    .a_rd_i       (a_rd),
    .a_veri_i     (a_veri),
    .b_gecerli_i  (b_gecerli),
    .b_hazir_o    (b_hazir),
    .b_rd_i       (b_rd),
    .b_veri_i     (b_veri),
    .yaz_gecerli_o(yaz_gecerli),
    .yaz_hazir_i  (yaz_hazir),
    .yaz_rd_o     (yaz_rd),
    .yaz_veri_o   (yaz_veri),
    .yaz_kaynak_o (yaz_kaynak)
  );

  task automatic chk(input string ad, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", ad, act, exp);
    end
  endtask

  // Monitor: every consumed write is matched against its source queue; held outputs must not move.
  logic        onceki_tut = 1'b0;
  logic [4:0]  onceki_rd;
  logic [31:0] onceki_veri;
  logic        onceki_kaynak;
  initial begin
    beklenen_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (onceki_tut) begin
          chk("tut_gecerli", yaz_gecerli, 1'b1);
          chk("tut_rd", yaz_rd, onceki_rd);
          chk("tut_veri", yaz_veri, onceki_veri);
          chk("tut_kaynak", yaz_kaynak, onceki_kaynak);
        end
        if (yaz_gecerli && yaz_hazir) begin
          chk("rd_sifir_degil", yaz_rd != 5'd0, 1'b1);
          if ((yaz_kaynak ? qb.size() : qa.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL beklenmeyen_yazma actual=rd%0d/%0h kaynak=%0d required=no write", yaz_rd, yaz_veri, yaz_kaynak);
          end else begin
            e = yaz_kaynak ? qb.pop_front() : qa.pop_front();
            chk(yaz_kaynak ? "b_rd" : "a_rd", yaz_rd, e.rd);
            chk(yaz_kaynak ? "b_veri" : "a_veri", yaz_veri, e.veri);
          end
        end
        onceki_tut    = yaz_gecerli && !yaz_hazir && !temizle;
        onceki_rd     = yaz_rd;
        onceki_veri   = yaz_veri;
        onceki_kaynak = yaz_kaynak;
      end else begin
        onceki_tut = 1'b0;
      end
    end
  end

  task automatic yari();
    @(negedge clk);
  endtask

  // Record handshakes completing at the coming edge; flush drops everything buffered.
  task automatic bitir();
    if (rst_n && temizle) begin
      qa.delete();
      qb.delete();
    end
    if (rst_n && a_gecerli && a_hazir && a_rd != 5'd0) qa.push_back('{a_rd, a_veri});
    if (rst_n && b_gecerli && b_hazir && b_rd != 5'd0) qb.push_back('{b_rd, b_veri});
    @(posedge clk);
    #1;
  endtask

  task automatic adim();
    yari();
    bitir();
  endtask

  task automatic surA(input logic g, input logic [4:0] rd, input logic [31:0] v);
    a_gecerli = g; a_rd = rd; a_veri = v;
  endtask

  task automatic surB(input logic g, input logic [4:0] rd, input logic [31:0] v);
    b_gecerli = g; b_rd = rd; b_veri = v;
  endtask

  task automatic cikis(input string ad, input logic g, input logic [4:0] rd,
                       input logic [31:0] v, input logic k);
    chk({ad, "_gecerli"}, yaz_gecerli, g);
    if (g) begin
      chk({ad, "_rd"}, yaz_rd, rd);
      chk({ad, "_veri"}, yaz_veri, v);
      chk({ad, "_kaynak"}, yaz_kaynak, k);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL zaman_asimi actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; temizle = 1'b0; yaz_hazir = 1'b0;
    surA(0, 0, 0); surB(0, 0, 0);
    repeat (2) @(negedge clk);
    cikis("reset", 1'b0, 0, 0, 0);
    chk("reset_rd", yaz_rd, 5'd0);
    chk("reset_veri", yaz_veri, 32'd0);
    chk("reset_kaynak", yaz_kaynak, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    yari();
    chk("reset_a_hazir", a_hazir, 1'b1);
    chk("reset_b_hazir", b_hazir, 1'b1);
    bitir();

    // Single A result, 1-cycle latency
    yaz_hazir = 1'b1;
    surA(1, 3, 32'h0000_00AB);
    adim();
    surA(0, 0, 0);
    yari(); cikis("tek", 1, 3, 32'hAB, 0); bitir();
    yari(); chk("tek_sonra_gecerli", yaz_gecerli, 1'b0); bitir();

    // Simultaneous A/B: A wins first tie, B wins the next
    surA(1, 1, 32'h11); surB(1, 2, 32'h22);
    adim();
    surA(0, 0, 0); surB(0, 0, 0);
    yari(); cikis("rr1_ilk", 1, 1, 32'h11, 0); bitir();
    yari(); cikis("rr1_ikinci", 1, 2, 32'h22, 1); bitir();
    surA(1, 1, 32'h11); surB(1, 2, 32'h22);
    adim();
    surA(0, 0, 0); surB(0, 0, 0);
    yari(); cikis("rr2_ilk", 1, 2, 32'h22, 1); bitir();
    yari(); cikis("rr2_ikinci", 1, 1, 32'h11, 0); bitir();
    yari(); chk("rr2_sonra_gecerli", yaz_gecerli, 1'b0); bitir();

    // Backpressure: three A results, output held, FIFO fills
    yaz_hazir = 1'b0;
    surA(1, 4, 32'h44); adim();
    surA(1, 5, 32'h55); adim();
    surA(1, 6, 32'h66); adim();
    surA(1, 9, 32'h99);
    yari();
    chk("bp_a_hazir", a_hazir, 1'b0);
    cikis("bp_tut", 1, 4, 32'h44, 0);
    bitir();
    surA(0, 0, 0);
    yaz_hazir = 1'b1;
    yari(); cikis("bp_1", 1, 4, 32'h44, 0); bitir();
    yari(); cikis("bp_2", 1, 5, 32'h55, 0); bitir();
    yari(); cikis("bp_3", 1, 6, 32'h66, 0); bitir();
    yari(); chk("bp_son_gecerli", yaz_gecerli, 1'b0); bitir();

    // rd=0 is accepted but never written
    surA(1, 0, 32'hFFFF_FFFF);
    yari(); chk("x0_hazir", a_hazir, 1'b1); bitir();
    surA(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      yari(); chk("x0_gecerli", yaz_gecerli, 1'b0); bitir();
    end

    // Fill both FIFOs, then flush
    yaz_hazir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      surA(1, 5'(10 + i), 32'hA0 + i);
      surB(1, 5'(20 + i), 32'hB0 + i);
      adim();
    end
    yari();
    chk("dolu_a_hazir", a_hazir, 1'b0);
    chk("dolu_b_hazir", b_hazir, 1'b0);
    bitir();
    temizle = 1'b1;
    surA(1, 13, 32'hDEAD); surB(1, 23, 32'hBEEF);
    yari();
    chk("temizle_a_hazir", a_hazir, 1'b0);
    chk("temizle_b_hazir", b_hazir, 1'b0);
    bitir();
    temizle = 1'b0;
    surB(0, 0, 0);
    surA(1, 7, 32'h77);
    yaz_hazir = 1'b1;
    yari();
    chk("temizle_sonra_gecerli", yaz_gecerli, 1'b0);
    chk("temizle_sonra_a_hazir", a_hazir, 1'b1);
    chk("temizle_sonra_b_hazir", b_hazir, 1'b1);
    bitir();
    surA(0, 0, 0);
    yari(); cikis("temizle_yeni", 1, 7, 32'h77, 0); bitir();
    yari(); chk("temizle_yeni_sonra", yaz_gecerli, 1'b0); bitir();

    // Asynchronous reset while a write is pending
    yaz_hazir = 1'b0;
    surA(1, 8, 32'h88); adim();
    surA(1, 9, 32'h89); adim();
    surA(0, 0, 0);
    chk("ar_once_gecerli", yaz_gecerli, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gecerli", yaz_gecerli, 1'b0);
    chk("ar_rd", yaz_rd, 5'd0);
    chk("ar_veri", yaz_veri, 32'd0);
    qa.delete(); qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    yaz_hazir = 1'b1;
    surA(1, 9, 32'h99); surB(1, 10, 32'hA0A0);
    adim();
    surA(0, 0, 0); surB(0, 0, 0);
    yari(); cikis("ar_sonra_1", 1, 9, 32'h99, 0); bitir();
    yari(); cikis("ar_sonra_2", 1, 10, 32'hA0A0, 1); bitir();
    yari(); chk("ar_sonra_bos", yaz_gecerli, 1'b0); bitir();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      surA($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      surB($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom);
      temizle   = ($urandom_range(0, 49) == 0);
      yaz_hazir = temizle ? 1'b0 : ($urandom_range(0, 3) != 0);
      adim();
    end
    temizle = 1'b0;
    surA(0, 0, 0); surB(0, 0, 0);
    yaz_hazir = 1'b1;
    repeat (12) adim();
    chk("son_qa_bos", qa.size(), 0);
    chk("son_qb_bos", qb.size(), 0);
    chk("son_gecerli", yaz_gecerli, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
